sm_regdump: RTL and testbench

- Debug-port reader for the CPU. Drives the CPU debug register address and samples the returned register data. Register address 0 returns the PC; addresses 1..31 return GPRs.
- Walks a configurable register range and transmits each value as an ASCII hex line over a UART 8N1 serial output.
- Sits beside the CPU at board top level, in place of the switch/display debug access.

---
 rtl/sm_regdump.sv | 138 +++++++++++++
 tb/tb_sm_regdump.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_regdump.sv
// Walks debug registers REG_FIRST..REG_LAST and prints each one as an ASCII hex line on a UART 8N1 txd.
// Per register: 1 ADDR cycle + 10 chars (13 with SM_REGDUMP_ADDR_PREFIX_EN, "II:" prefix) of 10*CLK_DIV cycles; start ignored while busy.
module sm_regdump #(
  parameter int CLK_DIV   = 16,
  parameter int REG_FIRST = 0,
  parameter int REG_LAST  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef SM_REGDUMP_ADDR_PREFIX_EN
  localparam int LINE_CHARS = 13;
  localparam int DIGIT0     = 3;
`else
  localparam int LINE_CHARS = 10;
  localparam int DIGIT0     = 0;
`endif
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [3:0]    CHAR_LAST = 4'(LINE_CHARS - 1);
  localparam logic [3:0]    DIGIT0_4  = 4'(DIGIT0);
  localparam logic [4:0]    IDX_FIRST = 5'(REG_FIRST);
  localparam logic [4:0]    IDX_LAST  = 5'(REG_LAST);

  // LOAD is folded into the ADDR exit edge, so it is never resident.
  typedef enum logic [1:0] {IDLE, ADDR, LOAD, SEND} state_t;

  state_t        state;
  logic [TW-1:0] tick;
  logic [3:0]    bitCnt;
  logic [3:0]    charCnt;
  logic [4:0]    idx;
  logic [31:0]   snap;

  logic [3:0]    digit;
  logic [31:0]   shifted;
  logic [7:0]    curChar;

  assign regAddr = idx;

  function automatic logic [7:0] hexAscii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    digit   = charCnt - DIGIT0_4;
    shifted = snap << {digit, 2'b00};
    curChar = 8'h0A;
`ifdef SM_REGDUMP_ADDR_PREFIX_EN
    if (charCnt == 4'd0)
      curChar = hexAscii({3'b000, idx[4]});
    else if (charCnt == 4'd1)
      curChar = hexAscii(idx[3:0]);
    else if (charCnt == 4'd2)
      curChar = 8'h3A;
    else
`endif
    if (digit < 4'd8)
      curChar = hexAscii(shifted[31:28]);
    else if (digit == 4'd8)
      curChar = 8'h0D;
    else
      curChar = 8'h0A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= IDX_FIRST;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      tick    <= '0;
      bitCnt  <= '0;
      charCnt <= '0;
      snap    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          idx <= IDX_FIRST;
          if (start) begin
            state <= ADDR;
            busy  <= 1'b1;
          end
        end
        ADDR: begin
          // Snapshot decouples the line from later regData changes; start bit goes out immediately.
          snap    <= regData;
          state   <= SEND;
          tick    <= '0;
          bitCnt  <= '0;
          charCnt <= '0;
          txd     <= 1'b0;
        end
        LOAD: state <= SEND;
        SEND: begin
          if (tick != TICK_LAST) begin
            tick <= tick + TW'(1);
          end else begin
            tick <= '0;
            if (bitCnt != 4'd9) begin
              bitCnt <= bitCnt + 4'd1;
              txd    <= (bitCnt == 4'd8) ? 1'b1 : curChar[bitCnt[2:0]];
            end else if (charCnt != CHAR_LAST) begin
              bitCnt  <= '0;
              charCnt <= charCnt + 4'd1;
              txd     <= 1'b0;
            end else begin
              bitCnt  <= '0;
              charCnt <= '0;
              txd     <= 1'b1;
              if (idx == IDX_LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                idx   <= IDX_FIRST;
              end else begin
                idx   <= idx + 5'd1;
                state <= ADDR;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_regdump.sv
// Bench for sm_regdump: single-register and full-range instances, UART decoder, string-level line model.
module tb_sm_regdump;

  localparam int CD = 4;
`ifdef SM_REGDUMP_ADDR_PREFIX_EN
  localparam int          RW        = 13;
  localparam int          SI        = 5;
  localparam logic [31:0] FIRST_VAL = 32'h0;
`else
  localparam int          RW        = 10;
  localparam int          SI        = 3;
  localparam logic [31:0] FIRST_VAL = 32'h1234ABCD;
`endif
  localparam int LINE_CYC = 1 + RW * 10 * CD;

  logic        clk = 1'b0;
  logic [1:0]  rstV, startV, txdV, busyV, doneV;
  logic [4:0]  regAddrA, regAddrB;
  logic [31:0] regDataA, regDataB;
  logic [31:0] valA, pcB, saltB;
  logic        overA;
  logic [7:0]  rxA[$], rxB[$], expA[$], expB[$];
  string       HEX = "0123456789ABCDEF";
  int          nVec = 0;
  int          nBad = 0;

  always #5 clk = ~clk;

  assign regDataA = overA ? 32'hFFFFFFFF : ((regAddrA == 5'(SI)) ? valA : 32'hDEAD0000);
  assign regDataB = (regAddrB == 5'd0) ? pcB : (({27'h0, regAddrB} ^ 32'hA5A5A5A5) ^ saltB);

  sm_regdump #(.CLK_DIV(CD), .REG_FIRST(SI), .REG_LAST(SI)) uA (
    .clk(clk), .rst(rstV[0]), .start(startV[0]), .regAddr(regAddrA), .regData(regDataA),
    .txd(txdV[0]), .busy(busyV[0]), .done(doneV[0]));

  sm_regdump #(.CLK_DIV(CD), .REG_FIRST(0), .REG_LAST(31)) uB (
    .clk(clk), .rst(rstV[1]), .start(startV[1]), .regAddr(regAddrB), .regData(regDataB),
    .txd(txdV[1]), .busy(busyV[1]), .done(doneV[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line text from the value alone.
  task automatic expLine(input int ch, input int idx, input logic [31:0] v);
    logic [7:0] s[$];
`ifdef SM_REGDUMP_ADDR_PREFIX_EN
    s.push_back(HEX[idx / 16]);
    s.push_back(HEX[idx % 16]);
    s.push_back(8'h3A);
`endif
    for (int k = 7; k >= 0; k--) s.push_back(HEX[int'((v >> (4 * k)) & 32'hF)]);
    s.push_back(8'h0D);
    s.push_back(8'h0A);
    foreach (s[i]) begin
      if (ch == 0) expA.push_back(s[i]);
      else expB.push_back(s[i]);
    end
  endtask

  task automatic uartMon(input int ch);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (txdV[ch] === 1'b0) begin
        repeat (CD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CD) @(negedge clk);
          b[i] = txdV[ch];
        end
        repeat (CD) @(negedge clk);
        chk("stop_bit", {31'h0, txdV[ch]}, 32'h1);
        if (ch == 0) rxA.push_back(b);
        else rxB.push_back(b);
      end
    end
  endtask

  task automatic cmpRx(input int ch, input string tag);
    logic [7:0] r[$], e[$];
    int n;
    if (ch == 0) begin r = rxA; e = expA; rxA.delete(); expA.delete(); end
    else begin r = rxB; e = expB; rxB.delete(); expB.delete(); end
    chk({tag, "_len"}, r.size(), e.size());
    n = (r.size() < e.size()) ? r.size() : e.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_ch%0d", tag, i), {24'h0, r[i]}, {24'h0, e[i]});
  endtask

  // Ends in the ADDR cycle of the new dump.
  task automatic pulseStart(input int ch);
    @(negedge clk);
    startV[ch] = 1'b1;
    @(negedge clk);
    startV[ch] = 1'b0;
  endtask

  // Entered at cycle 1 of busy; returns at the first negedge with busy low.
  task automatic waitIdle(input int ch, input int pokeAt, input bit ovr, output int cyc);
    int dB;
    dB  = 0;
    cyc = 1;
    for (int g = 0; g < 20000; g++) begin
      @(negedge clk);
      if (!busyV[ch]) break;
      cyc++;
      if (doneV[ch]) dB++;
      if (pokeAt > 0) startV[ch] = (cyc == pokeAt);
      if (ovr && cyc == 2) overA = 1'b1;
    end
    chk("busy_timeout", {31'h0, busyV[ch]}, 32'h0);
    chk("done_while_busy", dB, 0);
    chk("done_pulse", {31'h0, doneV[ch]}, 32'h1);
  endtask

  initial begin
    int cyc, bad;
    rstV = 2'b11; startV = 2'b00; overA = 1'b0;
    valA = FIRST_VAL; pcB = 32'h10; saltB = 32'h0;
    fork
      uartMon(0);
      uartMon(1);
    join_none
    repeat (2) @(negedge clk);
    rstV = 2'b00;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_txd", {30'h0, txdV}, 32'h3);
      chk("idle_busy", {30'h0, busyV}, 32'h0);
      chk("idle_done", {30'h0, doneV}, 32'h0);
      chk("idle_addrA", regAddrA, SI);
      chk("idle_addrB", regAddrB, 0);
    end

    // Single register: fixed value, late regData change, then random values.
    for (int t = 0; t < 6; t++) begin
      overA = 1'b0;
      if (t >= 2) valA = $urandom;
      expLine(0, SI, valA);
      pulseStart(0);
      chk("A_addr", regAddrA, SI);
      chk("A_busy", {31'h0, busyV[0]}, 32'h1);
      waitIdle(0, 0, (t % 2) == 1, cyc);
      chk("A_busy_cycles", cyc, LINE_CYC);
      @(negedge clk);
      chk("A_done_once", {31'h0, doneV[0]}, 32'h0);
      overA = 1'b0;
      cmpRx(0, $sformatf("A%0d", t));
    end

    // Start held high: a second dump begins on the done edge.
    valA = $urandom;
    expLine(0, SI, valA);
    expLine(0, SI, valA);
    @(negedge clk);
    startV[0] = 1'b1;
    @(negedge clk);
    waitIdle(0, 0, 0, cyc);
    chk("hold_cycles1", cyc, LINE_CYC);
    @(negedge clk);
    chk("hold_restart", {31'h0, busyV[0]}, 32'h1);
    chk("hold_addr", regAddrA, SI);
    startV[0] = 1'b0;
    waitIdle(0, 0, 0, cyc);
    chk("hold_cycles2", cyc, LINE_CYC);
    @(negedge clk);
    cmpRx(0, "hold");

    // Full range with a redundant start at cycle 100.
    for (int a = 0; a < 32; a++) expLine(1, a, (a == 0) ? pcB : (32'(a) ^ 32'hA5A5A5A5 ^ saltB));
    pulseStart(1);
    chk("B_addr0", regAddrB, 0);
    waitIdle(1, 100, 0, cyc);
    startV[1] = 1'b0;
    chk("B_busy_cycles", cyc, 32 * LINE_CYC);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (busyV[1] || doneV[1]) bad++;
    end
    chk("B_no_requeue", bad, 0);
    cmpRx(1, "B");

    // Reset mid-character aborts the dump.
    pulseStart(1);
    repeat (249) @(negedge clk);
    rstV[1] = 1'b1;
    @(negedge clk);
    chk("abort_txd", {31'h0, txdV[1]}, 32'h1);
    chk("abort_busy", {31'h0, busyV[1]}, 32'h0);
    chk("abort_done", {31'h0, doneV[1]}, 32'h0);
    chk("abort_addr", regAddrB, 0);
    rstV[1] = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (doneV[1] || busyV[1] || !txdV[1]) bad++;
    end
    chk("abort_quiet", bad, 0);
    rxB.delete();
    expB.delete();

    // Fresh dump after abort, random PC and data salt.
    pcB = $urandom;
    saltB = $urandom;
    for (int a = 0; a < 32; a++) expLine(1, a, (a == 0) ? pcB : (32'(a) ^ 32'hA5A5A5A5 ^ saltB));
    pulseStart(1);
    chk("B2_addr0", regAddrB, 0);
    waitIdle(1, 0, 0, cyc);
    chk("B2_busy_cycles", cyc, 32 * LINE_CYC);
    @(negedge clk);
    chk("B2_done_once", {31'h0, doneV[1]}, 32'h0);
    cmpRx(1, "B2");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
